// File: rtl/dmem_responder_pkg.sv
//------------------------------------------------------------------------------
// Module   : dmem_responder_pkg
// Purpose  : Shared types and constants for the data-memory responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_responder_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Error cause; only "any error" reaches the bus today, but the cause is
  // kept separate so a richer error code can be exposed later.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_cause_e;

  // Misalignment takes priority over range when both apply.
  function automatic err_cause_e classify_err(input logic misalign, input logic out_of_range);
    err_cause_e c;
    c = ERR_NONE;
    if (misalign) begin
      c = ERR_MISALIGN;
    end else if (out_of_range) begin
      c = ERR_RANGE;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_if.sv
//------------------------------------------------------------------------------
// Module   : dmem_responder_if
// Purpose  : Request/response valid-ready bundle between load/store initiator
//            and the data-memory responder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [XLEN-1:0]   req_addr;
  logic              req_we;
  logic [XLEN-1:0]   req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/dmem_word_array.sv
//------------------------------------------------------------------------------
// Module   : dmem_word_array
// Purpose  : DEPTH_WORDS x 32 single-port storage, byte-enabled synchronous
//            write, asynchronous read, no reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_word_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  wire logic                           clk,
  input  wire logic                           we_i,
  input  wire logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  wire logic [XLEN-1:0]                wdata_i,
  input  wire logic [BE_W-1:0]                be_i,
  output logic      [XLEN-1:0]                rdata_o
);

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];

  // Byte-lane write: only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : dmem_responder
// Purpose  : Data-memory target with programmable wait states. Accepts one
//            request, waits WAIT_CYCLES, commits store / samples load, then
//            holds the response until the initiator takes it.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned     DEPTH_WORDS = 256,
  parameter int unsigned     WAIT_CYCLES = 2,
  parameter logic [XLEN-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input wire logic         clk,
  input wire logic         rst,   // synchronous, active-low
  dmem_responder_if.slave  bus
);

  localparam int              IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]      WAIT_INIT  = 4'(WAIT_CYCLES);

  if (WAIT_CYCLES > 15) begin : g_chk_wait
    $error("dmem_responder: WAIT_CYCLES must be 0..15");
  end
  if ((DEPTH_WORDS < 4) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_chk_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 4");
  end

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            we_q;
  logic [BE_W-1:0] be_q;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            w_req_ready;
  logic            w_accept;
  logic            w_commit;
  logic [XLEN-1:0] w_cmd_addr, w_cmd_wdata, w_offset, w_mem_rdata;
  logic            w_cmd_we;
  logic [BE_W-1:0] w_cmd_be;
  err_cause_e      w_cause;
  logic            w_err;

  assign w_req_ready = (state_q == ST_IDLE) && rst;
  assign w_accept    = bus.req_valid && w_req_ready;

  // With zero wait states the commit happens on the accept edge itself, so
  // the live bus fields are used while in IDLE; otherwise the captured copy.
  assign w_cmd_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
  assign w_cmd_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
  assign w_cmd_we    = (state_q == ST_IDLE) ? bus.req_we    : we_q;
  assign w_cmd_be    = (state_q == ST_IDLE) ? bus.req_be    : be_q;

  // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
  assign w_offset = w_cmd_addr - BASE_ADDR;
  assign w_cause  = classify_err(w_cmd_addr[1:0] != 2'b00, w_offset >= SPAN_BYTES);
  assign w_err    = (w_cause != ERR_NONE);

  assign w_commit = rst &&
                    (((state_q == ST_IDLE) && w_accept && (WAIT_CYCLES == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == 4'd1)));

  dmem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (w_commit && w_cmd_we && !w_err),
    .idx_i   (w_offset[IDX_W+1:2]),
    .wdata_i (w_cmd_wdata),
    .be_i    (w_cmd_be),
    .rdata_o (w_mem_rdata)
  );

  // Next-state, wait counter and response data
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (w_commit) begin
      rdata_d = (!w_err && !w_cmd_we) ? w_mem_rdata : '0;
      err_d   = w_err;
    end
  end

  // State, counter, captured request and response registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (w_accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        we_q    <= bus.req_we;
        be_q    <= bus.req_be;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder (WAIT_CYCLES=2
//            instance A, WAIT_CYCLES=0 instance B).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  // Issue one request to instance A (sel=0) or B (sel=1) with rsp_ready high.
  // lat counts edges from the accept edge (=1) to the edge after which
  // rsp_valid is first seen.
  task automatic txn(input bit sel, input logic [31:0] addr, input logic we,
                     input logic [31:0] wdata, input logic [3:0] be,
                     output int lat, output logic [31:0] rdata,
                     output logic err, output bit seen);
    @(negedge clk);
    if (!sel) begin
      bus_a.req_valid = 1'b1; bus_a.req_addr = addr; bus_a.req_we = we;
      bus_a.req_wdata = wdata; bus_a.req_be = be; bus_a.rsp_ready = 1'b1;
    end else begin
      bus_b.req_valid = 1'b1; bus_b.req_addr = addr; bus_b.req_we = we;
      bus_b.req_wdata = wdata; bus_b.req_be = be; bus_b.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    bus_b.req_valid = 1'b0;
    lat  = 1;
    seen = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    end
    rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (bus_a.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus_a.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus_a.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h expected 00000000", bus_a.rsp_rdata); else pass_cnt++;
    total_cnt++; if (bus_a.rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b expected 0", bus_a.rsp_err); else pass_cnt++;
    total_cnt++; if (bus_a.req_ready !== 1'b0) $display("FAIL reset_req_ready_low: got %b expected 0", bus_a.req_ready); else pass_cnt++;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (bus_a.req_ready !== 1'b1) $display("FAIL idle_req_ready_a: got %b expected 1", bus_a.req_ready); else pass_cnt++;
    total_cnt++; if (bus_b.req_ready !== 1'b1) $display("FAIL idle_req_ready_b: got %b expected 1", bus_b.req_ready); else pass_cnt++;
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er; bit seen;
    txn(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, lat, rd, er, seen);
    total_cnt++; if (!seen) $display("FAIL store_rsp_seen: got 0 expected 1"); else pass_cnt++;
    total_cnt++; if (lat !== 3) $display("FAIL store_latency: got %0d expected 3", lat); else pass_cnt++;
    total_cnt++; if (er !== 1'b0) $display("FAIL store_err: got %b expected 0", er); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL store_rdata: got %h expected 00000000", rd); else pass_cnt++;
    txn(0, 32'h10, 1'b0, 32'h0, 4'h0, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h expected deadbeef", rd); else pass_cnt++;
    total_cnt++; if (lat !== 3) $display("FAIL load_latency: got %0d expected 3", lat); else pass_cnt++;
  endtask

  task automatic test_byte_merge();
    int lat; logic [31:0] rd; logic er; bit seen;
    txn(0, 32'h10, 1'b1, 32'h00AA0000, 4'b0100, lat, rd, er, seen);
    txn(0, 32'h10, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'hDEAABEEF) $display("FAIL byte_merge: got %h expected deaabeef", rd); else pass_cnt++;
    txn(0, 32'h10, 1'b1, 32'h11223344, 4'b0000, lat, rd, er, seen);
    total_cnt++; if (er !== 1'b0) $display("FAIL be_zero_err: got %b expected 0", er); else pass_cnt++;
    txn(0, 32'h10, 1'b0, 32'h0, 4'h0, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'hDEAABEEF) $display("FAIL be_zero_noop: got %h expected deaabeef", rd); else pass_cnt++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er; bit seen;
    txn(0, 32'h12, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (er !== 1'b1) $display("FAIL misalign_load_err: got %b expected 1", er); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL misalign_load_rdata: got %h expected 00000000", rd); else pass_cnt++;
    txn(0, 32'h13, 1'b1, 32'hFFFFFFFF, 4'hF, lat, rd, er, seen);
    total_cnt++; if (er !== 1'b1) $display("FAIL misalign_store_err: got %b expected 1", er); else pass_cnt++;
    txn(0, 32'h10, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'hDEAABEEF) $display("FAIL misalign_store_nowrite: got %h expected deaabeef", rd); else pass_cnt++;
    txn(0, 32'h0, 1'b1, 32'h55AA1234, 4'hF, lat, rd, er, seen);
    txn(0, 32'h400, 1'b1, 32'hFFFFFFFF, 4'hF, lat, rd, er, seen);
    total_cnt++; if (er !== 1'b1) $display("FAIL range_store_err: got %b expected 1", er); else pass_cnt++;
    txn(0, 32'h0, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'h55AA1234) $display("FAIL range_store_nowrite: got %h expected 55aa1234", rd); else pass_cnt++;
    txn(0, 32'h3FC, 1'b1, 32'hA5A5C3C3, 4'hF, lat, rd, er, seen);
    total_cnt++; if (er !== 1'b0) $display("FAIL last_word_err: got %b expected 0", er); else pass_cnt++;
    txn(0, 32'h3FC, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'hA5A5C3C3) $display("FAIL last_word_rdata: got %h expected a5a5c3c3", rd); else pass_cnt++;
    txn(0, 32'hFFFF_FFFC, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (er !== 1'b1) $display("FAIL high_addr_err: got %b expected 1", er); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_addr = 32'h10; bus_a.req_we = 1'b0;
    bus_a.req_wdata = 32'h0; bus_a.req_be = 4'hF; bus_a.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    n = 0;
    while (!bus_a.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total_cnt++; if (bus_a.rsp_valid !== 1'b1) $display("FAIL bp_rsp_arrives: got %b expected 1", bus_a.rsp_valid); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total_cnt++; if (bus_a.rsp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus_a.rsp_valid); else pass_cnt++;
      total_cnt++; if (bus_a.rsp_rdata !== 32'hDEAABEEF) $display("FAIL bp_hold_rdata[%0d]: got %h expected deaabeef", i, bus_a.rsp_rdata); else pass_cnt++;
      total_cnt++; if (bus_a.rsp_err !== 1'b0) $display("FAIL bp_hold_err[%0d]: got %b expected 0", i, bus_a.rsp_err); else pass_cnt++;
      total_cnt++; if (bus_a.req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, bus_a.req_ready); else pass_cnt++;
    end
    @(negedge clk); bus_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (bus_a.rsp_valid !== 1'b0) $display("FAIL bp_release_valid: got %b expected 0", bus_a.rsp_valid); else pass_cnt++;
    total_cnt++; if (bus_a.req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", bus_a.req_ready); else pass_cnt++;
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd; logic er; bit seen;
    bit any_valid;
    txn(0, 32'h20, 1'b1, 32'h11112222, 4'hF, lat, rd, er, seen);
    @(negedge clk);
    bus_a.req_valid = 1'b1; bus_a.req_addr = 32'h20; bus_a.req_we = 1'b1;
    bus_a.req_wdata = 32'h12345678; bus_a.req_be = 4'hF; bus_a.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    any_valid = bus_a.rsp_valid;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      any_valid = any_valid | bus_a.rsp_valid;
    end
    total_cnt++; if (any_valid !== 1'b0) $display("FAIL midwait_no_rsp: got %b expected 0", any_valid); else pass_cnt++;
    total_cnt++; if (bus_a.req_ready !== 1'b1) $display("FAIL midwait_idle: got %b expected 1", bus_a.req_ready); else pass_cnt++;
    txn(0, 32'h20, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'h11112222) $display("FAIL midwait_no_write: got %h expected 11112222", rd); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic er; bit seen;
    txn(0, 32'h30, 1'b1, 32'h0BADF00D, 4'hF, lat, rd, er, seen);
    txn(0, 32'h30, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'h0BADF00D) $display("FAIL b2b_rdata: got %h expected 0badf00d", rd); else pass_cnt++;
    txn(0, 32'h30, 1'b1, 32'h00000077, 4'b0001, lat, rd, er, seen);
    txn(0, 32'h30, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (rd !== 32'h0BADF077) $display("FAIL b2b_lane0: got %h expected 0badf077", rd); else pass_cnt++;
  endtask

  task automatic test_wait0();
    int lat; logic [31:0] rd; logic er; bit seen;
    txn(1, 32'h8, 1'b1, 32'hCAFEF00D, 4'hF, lat, rd, er, seen);
    total_cnt++; if (lat !== 1) $display("FAIL w0_store_latency: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++; if (er !== 1'b0) $display("FAIL w0_store_err: got %b expected 0", er); else pass_cnt++;
    txn(1, 32'h8, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (lat !== 1) $display("FAIL w0_load_latency: got %0d expected 1", lat); else pass_cnt++;
    total_cnt++; if (rd !== 32'hCAFEF00D) $display("FAIL w0_load_rdata: got %h expected cafef00d", rd); else pass_cnt++;
    txn(1, 32'h9, 1'b0, 32'h0, 4'hF, lat, rd, er, seen);
    total_cnt++; if (er !== 1'b1) $display("FAIL w0_misalign_err: got %b expected 1", er); else pass_cnt++;
    total_cnt++; if (rd !== 32'h0) $display("FAIL w0_misalign_rdata: got %h expected 00000000", rd); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_we = 1'b0;
    bus_a.req_wdata = '0; bus_a.req_be = '0; bus_a.rsp_ready = 1'b1;
    bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_we = 1'b0;
    bus_b.req_wdata = '0; bus_b.req_be = '0; bus_b.rsp_ready = 1'b1;

    test_reset();
    test_store_load();
    test_byte_merge();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    test_wait0();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
